shot_frame_ctl: RTL

- Sequences one light-gun shot. On an accepted trigger it forces the display black for DARK_FRAMES frames, then draws targets white for one frame. It samples the filtered photodetector across both phases and issues a single hit or miss pulse.
- When no gun is connected, it takes mouse clicks instead and resolves them immediately.
- Sits between the gun/mouse inputs and game logic. Drives the override inputs of the draw pipeline. It is the sole arbiter between the gun and mouse shot sources.

---
 rtl/shot_pkg.sv | 25 ++
 rtl/sync_edge.sv | 41 ++++
 rtl/shot_frame_ctl.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/shot_pkg.sv
// ---------------------------------------------------------------------------
// shot_pkg
// Shared definitions for the light-gun shot sequencer.
//   shot_state_t     : sequencer states
//   MAX_DARK_FRAMES  : upper bound on the number of black frames
//   cnt_width()      : bits needed to count from 0 up to a given value
// ---------------------------------------------------------------------------
package shot_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WAIT_DARK,
      DARK,
      TARGET,
      RESULT,
      COOLDOWN
   } shot_state_t;

   localparam int MAX_DARK_FRAMES = 7;

   function automatic int cnt_width(input int max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/sync_edge.sv
// ---------------------------------------------------------------------------
// sync_edge
// Two-flop synchronizer for an asynchronous level, plus a registered
// rising-edge pulse. The pulse appears 3 clk edges after the raw edge.
//   clk      : clock
//   rst      : asynchronous active-high reset
//   i_async  : raw asynchronous input
//   o_level  : synchronized level
//   o_rise   : one-cycle pulse on a synchronized rising edge
// ---------------------------------------------------------------------------
module sync_edge (
   input  logic clk,
   input  logic rst,
   input  logic i_async,
   output logic o_level,
   output logic o_rise
);

   logic r_meta;
   logic r_sync;
   logic r_sync_d;
   logic r_rise;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_meta   <= 1'b0;
         r_sync   <= 1'b0;
         r_sync_d <= 1'b0;
         r_rise   <= 1'b0;
      end else begin
         r_meta   <= i_async;
         r_sync   <= r_meta;
         r_sync_d <= r_sync;
         r_rise   <= r_sync & ~r_sync_d;
      end
   end

   assign o_level = r_sync;
   assign o_rise  = r_rise;

endmodule

// File: rtl/shot_frame_ctl.sv
// ---------------------------------------------------------------------------
// shot_frame_ctl
// Sequences one light-gun shot: on an accepted trigger the screen goes black
// for DARK_FRAMES frames, then targets are drawn white for one frame, and the
// filtered photodetector decides hit or miss. Without a gun, mouse clicks are
// resolved immediately from mouse_on_target.
//   clk, rst            : clock, asynchronous active-high reset
//   frame_start         : one-cycle pulse at each frame start
//   gun_is_connected    : selects gun (1) or mouse (0) as shot source
//   gun_trigger         : raw asynchronous trigger
//   gun_photodetector   : raw asynchronous detector
//   mouse_left          : synchronous left button level
//   mouse_on_target     : cursor is over a target
//   force_black         : draw pipeline outputs all black
//   force_target        : draw pipeline outputs white targets on black
//   shot_fired          : pulse, shot accepted
//   hit, miss           : pulse, shot outcome (exactly one per resolved shot)
//   busy                : high whenever the sequencer is not idle
// ---------------------------------------------------------------------------
module shot_frame_ctl #(
   parameter int DARK_FRAMES     = 1,
   parameter int MIN_HIT_CYCLES  = 64,
   parameter int COOLDOWN_FRAMES = 15
) (
   input  logic clk,
   input  logic rst,
   input  logic frame_start,
   input  logic gun_is_connected,
   input  logic gun_trigger,
   input  logic gun_photodetector,
   input  logic mouse_left,
   input  logic mouse_on_target,
   output logic force_black,
   output logic force_target,
   output logic shot_fired,
   output logic hit,
   output logic miss,
   output logic busy
);
   import shot_pkg::*;

   localparam int RUN_W = $clog2(MIN_HIT_CYCLES + 1);
   localparam int FRM_W = cnt_width((COOLDOWN_FRAMES > MAX_DARK_FRAMES) ?
                                    COOLDOWN_FRAMES : MAX_DARK_FRAMES);
   localparam logic [RUN_W-1:0] RUN_MAX   = RUN_W'(MIN_HIT_CYCLES);
   localparam logic [FRM_W-1:0] DARK_LAST = FRM_W'(DARK_FRAMES);
   localparam logic [FRM_W-1:0] COOL_LAST = FRM_W'(COOLDOWN_FRAMES);

   logic              w_trig_rise;
   logic              w_trig_level_unused;
   logic              w_pd_level;
   logic              w_pd_rise_unused;
   logic              w_mouse_rise;
   logic              w_lit;
   logic [FRM_W-1:0]  w_frame_inc;

   shot_state_t       r_state;
   shot_state_t       w_state_nxt;
   logic              r_mouse_d;
   logic [RUN_W-1:0]  r_run_cnt;
   logic [FRM_W-1:0]  r_frame_cnt;
   logic [FRM_W-1:0]  w_frame_nxt;
   logic              r_hit_flag;
   logic              w_hit_flag_nxt;
   logic              r_ambient_flag;
   logic              w_ambient_nxt;
   logic              w_shot_nxt;
   logic              w_hit_nxt;
   logic              w_miss_nxt;

   logic              r_force_black;
   logic              r_force_target;
   logic              r_shot_fired;
   logic              r_hit;
   logic              r_miss;
   logic              r_busy;

   sync_edge u_trig_sync (
      .clk     (clk),
      .rst     (rst),
      .i_async (gun_trigger),
      .o_level (w_trig_level_unused),
      .o_rise  (w_trig_rise)
   );

   // Detector only needs the level; its edge pulse is left dangling.
   sync_edge u_pd_sync (
      .clk     (clk),
      .rst     (rst),
      .i_async (gun_photodetector),
      .o_level (w_pd_level),
      .o_rise  (w_pd_rise_unused)
   );

   assign w_mouse_rise = mouse_left & ~r_mouse_d;
   assign w_lit        = (r_run_cnt == RUN_MAX);
   assign w_frame_inc  = r_frame_cnt + FRM_W'(1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state        <= IDLE;
         r_mouse_d      <= 1'b0;
         r_run_cnt      <= '0;
         r_frame_cnt    <= '0;
         r_hit_flag     <= 1'b0;
         r_ambient_flag <= 1'b0;
         r_force_black  <= 1'b0;
         r_force_target <= 1'b0;
         r_shot_fired   <= 1'b0;
         r_hit          <= 1'b0;
         r_miss         <= 1'b0;
         r_busy         <= 1'b0;
      end else begin
         r_state        <= w_state_nxt;
         r_mouse_d      <= mouse_left;
         r_frame_cnt    <= w_frame_nxt;
         r_hit_flag     <= w_hit_flag_nxt;
         r_ambient_flag <= w_ambient_nxt;
         // A light run must lie entirely inside one phase, so any state
         // change restarts it.
         if (w_state_nxt != r_state) begin
            r_run_cnt <= '0;
         end else if (w_pd_level) begin
            if (r_run_cnt != RUN_MAX) begin
               r_run_cnt <= r_run_cnt + RUN_W'(1);
            end
         end else begin
            r_run_cnt <= '0;
         end
         // Overrides and busy follow the state being entered, so they are
         // valid from the first cycle spent in that state.
         r_force_black  <= (w_state_nxt == DARK);
         r_force_target <= (w_state_nxt == TARGET);
         r_busy         <= (w_state_nxt != IDLE);
         r_shot_fired   <= w_shot_nxt;
         r_hit          <= w_hit_nxt;
         r_miss         <= w_miss_nxt;
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_frame_nxt    = r_frame_cnt;
      w_hit_flag_nxt = r_hit_flag;
      w_ambient_nxt  = r_ambient_flag;
      w_shot_nxt     = 1'b0;
      w_hit_nxt      = 1'b0;
      w_miss_nxt     = 1'b0;
      case (r_state)
         IDLE: begin
            // Gun has priority; mouse clicks only count with no gun present.
            if (w_trig_rise && gun_is_connected) begin
               w_state_nxt = WAIT_DARK;
               w_shot_nxt  = 1'b1;
            end else if (w_mouse_rise && !gun_is_connected) begin
               w_state_nxt    = RESULT;
               w_shot_nxt     = 1'b1;
               w_hit_flag_nxt = mouse_on_target;
               w_ambient_nxt  = 1'b0;
            end
         end
         WAIT_DARK: begin
            if (!gun_is_connected) begin
               w_state_nxt = IDLE;
            end else if (frame_start) begin
               w_state_nxt = DARK;
               w_frame_nxt = '0;
            end
         end
         DARK: begin
            if (!gun_is_connected) begin
               w_state_nxt   = IDLE;
               w_ambient_nxt = 1'b0;
               w_hit_flag_nxt = 1'b0;
            end else begin
               // Light seen on a black screen means ambient light or a
               // gun aimed at a lamp; it vetoes the hit.
               if (w_lit) w_ambient_nxt = 1'b1;
               if (frame_start) begin
                  w_frame_nxt = w_frame_inc;
                  if (w_frame_inc == DARK_LAST) w_state_nxt = TARGET;
               end
            end
         end
         TARGET: begin
            if (!gun_is_connected) begin
               w_state_nxt    = IDLE;
               w_ambient_nxt  = 1'b0;
               w_hit_flag_nxt = 1'b0;
            end else begin
               if (w_lit) w_hit_flag_nxt = 1'b1;
               if (frame_start) w_state_nxt = RESULT;
            end
         end
         RESULT: begin
            w_hit_nxt      = r_hit_flag & ~r_ambient_flag;
            w_miss_nxt     = ~(r_hit_flag & ~r_ambient_flag);
            w_hit_flag_nxt = 1'b0;
            w_ambient_nxt  = 1'b0;
            w_frame_nxt    = '0;
            w_state_nxt    = (COOLDOWN_FRAMES == 0) ? IDLE : COOLDOWN;
         end
         COOLDOWN: begin
            if (frame_start) begin
               w_frame_nxt = w_frame_inc;
               if (w_frame_inc == COOL_LAST) w_state_nxt = IDLE;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   assign force_black  = r_force_black;
   assign force_target = r_force_target;
   assign shot_fired   = r_shot_fired;
   assign hit          = r_hit;
   assign miss         = r_miss;
   assign busy         = r_busy;

endmodule
